// File: rtl/xbus_sdram_initiator.sv
// -----------------------------------------------------------------------------
// xbus_sdram_initiator
//
// CADR-side initiator for the sdram request bus of the MiSTer RAM controller.
// It takes a CPU xbus cycle, which the CPU holds until it is acknowledged, and
// turns it into a single sdram_req or sdram_write strobe. It then waits for the
// controller's sdram_done/sdram_ready handshake, stretches the cycle to at least
// MIN_CYCLES, and returns a one-cycle xbus_ack that carries the read data.
// If the access stalls, it is abandoned after TIMEOUT_CYCLES. In that case
// xbus_timeout is pulsed and a read returns all ones.
//
// Optional feature: define XBUS_SDRAM_POSTED_WRITE_EN to post writes. The write
// is acked the cycle after acceptance and drains in the background.
//
// Ports
//   clk            system clock, shared by xbus and sdram bus
//   reset          synchronous, active-high
//   xbus_addr      CPU word address
//   xbus_data_in   CPU write data
//   xbus_req       level request, held until xbus_ack
//   xbus_write     1 = write, 0 = read, valid with xbus_req
//   xbus_data_out  read data, valid from the ack cycle until the next acceptance
//   xbus_ack       one-cycle completion pulse
//   xbus_timeout   one-cycle pulse when an sdram access is abandoned
//   xbus_busy      high whenever the FSM is not idle
//   sdram_addr     registered address to the controller
//   sdram_data_in  registered write data to the controller
//   sdram_data_out read data from the controller
//   sdram_req      read strobe
//   sdram_write    write strobe
//   sdram_done     controller idle; a strobe is taken when strobe & sdram_done
//   sdram_ready    read data valid on sdram_data_out
// -----------------------------------------------------------------------------
module xbus_sdram_initiator #(
  parameter int MIN_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [21:0] xbus_addr,
  input  logic [31:0] xbus_data_in,
  input  logic        xbus_req,
  input  logic        xbus_write,
  output logic [31:0] xbus_data_out,
  output logic        xbus_ack,
  output logic        xbus_timeout,
  output logic        xbus_busy,
  output logic [21:0] sdram_addr,
  output logic [31:0] sdram_data_in,
  input  logic [31:0] sdram_data_out,
  output logic        sdram_req,
  output logic        sdram_write,
  input  logic        sdram_done,
  input  logic        sdram_ready
);

  typedef enum logic [2:0] {
    IDLE, RD_CMD, RD_WAIT, WR_CMD, HOLD, ACK, RELEASE
  } state_t;

  // A minimum of 0 behaves the same as a minimum of 1.
  localparam int MIN_EFF = (MIN_CYCLES < 1) ? 1 : MIN_CYCLES;
  localparam int TO_EFF  = (TIMEOUT_CYCLES < 2) ? 2 : TIMEOUT_CYCLES;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_EFF - 1);
  // The decision is made one cycle early, so that ACK (and xbus_timeout)
  // is on the bus in the cycle where the counter reads TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_EFF - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             ack_q, to_q;
  logic [31:0]      data_out_q;
  logic [21:0]      addr_q;
  logic [31:0]      wdata_q;

  logic load, rd_capture, timeout_ev, to_hit;
  logic can_accept, wr_posted;

`ifdef XBUS_SDRAM_POSTED_WRITE_EN
  // A posted write has been acked, but the CPU has not dropped its request yet.
  // The request must be released before a new one is accepted.
  logic rel_pend_q;

  always_ff @(posedge clk) begin
    if (reset)                   rel_pend_q <= 1'b0;
    else if (load && xbus_write) rel_pend_q <= 1'b1;
    else if (!xbus_req)          rel_pend_q <= 1'b0;
  end

  assign can_accept = !rel_pend_q;
  assign wr_posted  = 1'b1;
`else
  assign can_accept = 1'b1;
  assign wr_posted  = 1'b0;
`endif

  // NOTE: every signal written here gets a default first. Otherwise a path
  // through the case that does not assign it would infer a latch.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    rd_capture = 1'b0;
    timeout_ev = 1'b0;
    to_hit     = (cnt_q >= TO_LAST);
    unique case (state_q)
      IDLE: if (xbus_req && can_accept) begin
        load    = 1'b1;
        state_d = xbus_write ? WR_CMD : RD_CMD;
      end
      // If the handshake and the timeout land in the same cycle, the handshake wins.
      RD_CMD: begin
        if (sdram_done) state_d = RD_WAIT;
        else if (to_hit) begin
          state_d    = ACK;
          timeout_ev = 1'b1;
        end
      end
      RD_WAIT: begin
        if (sdram_ready) begin
          state_d    = HOLD;
          rd_capture = 1'b1;
        end else if (to_hit) begin
          state_d    = ACK;
          timeout_ev = 1'b1;
        end
      end
      WR_CMD: begin
        if (sdram_done) state_d = wr_posted ? IDLE : HOLD;
        else if (to_hit) begin
          state_d    = wr_posted ? IDLE : ACK;
          timeout_ev = 1'b1;
        end
      end
      HOLD:    if (cnt_q >= HOLD_LAST) state_d = ACK;
      ACK:     state_d = RELEASE;
      RELEASE: if (!xbus_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments, so every register
  // in this block samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      to_q       <= 1'b0;
      data_out_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == ACK) || (load && xbus_write && wr_posted);
      to_q    <= timeout_ev;
      if (load) begin
        cnt_q   <= '0;
        addr_q  <= xbus_addr;
        wdata_q <= xbus_data_in;
      end else if (state_q != IDLE && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (rd_capture)
        data_out_q <= sdram_data_out;
      else if (timeout_ev && state_q != WR_CMD)
        data_out_q <= 32'hFFFF_FFFF;
    end
  end

  assign xbus_data_out = data_out_q;
  assign xbus_ack      = ack_q;
  assign xbus_timeout  = to_q;
  assign xbus_busy     = (state_q != IDLE);
  assign sdram_addr    = addr_q;
  assign sdram_data_in = wdata_q;
  assign sdram_req     = (state_q == RD_CMD);
  assign sdram_write   = (state_q == WR_CMD);

endmodule

// File: tb/tb_xbus_sdram_initiator.sv
// -----------------------------------------------------------------------------
// tb_xbus_sdram_initiator
//
// Self-checking bench for xbus_sdram_initiator (MIN_CYCLES=4, TIMEOUT_CYCLES=16).
// The bench drives inputs and samples outputs on the falling clock edge.
// Cycle 0 is the cycle in which the IDLE state sees xbus_req.
// The expected read data and timeout flag for each access are pushed to a
// scoreboard queue when the request is driven. They are popped and compared
// when xbus_ack appears.
// -----------------------------------------------------------------------------
module tb_xbus_sdram_initiator;

  localparam int MIN_CYCLES     = 4;
  localparam int TIMEOUT_CYCLES = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [21:0] xbus_addr;
  logic [31:0] xbus_data_in;
  logic        xbus_req;
  logic        xbus_write;
  logic [31:0] xbus_data_out;
  logic        xbus_ack;
  logic        xbus_timeout;
  logic        xbus_busy;
  logic [21:0] sdram_addr;
  logic [31:0] sdram_data_in;
  logic [31:0] sdram_data_out;
  logic        sdram_req;
  logic        sdram_write;
  logic        sdram_done;
  logic        sdram_ready;

  xbus_sdram_initiator #(
    .MIN_CYCLES    (MIN_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .xbus_addr     (xbus_addr),
    .xbus_data_in  (xbus_data_in),
    .xbus_req      (xbus_req),
    .xbus_write    (xbus_write),
    .xbus_data_out (xbus_data_out),
    .xbus_ack      (xbus_ack),
    .xbus_timeout  (xbus_timeout),
    .xbus_busy     (xbus_busy),
    .sdram_addr    (sdram_addr),
    .sdram_data_in (sdram_data_in),
    .sdram_data_out(sdram_data_out),
    .sdram_req     (sdram_req),
    .sdram_write   (sdram_write),
    .sdram_done    (sdram_done),
    .sdram_ready   (sdram_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        timeout;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_rd = 32'h0;  // what xbus_data_out should currently hold

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Ack cycle for a handshake that leaves RD_WAIT/WR_CMD in cycle h.
  // HOLD runs in cycle h+1 with the counter at h, and ACK follows once the
  // counter reaches MIN_CYCLES-1.
  function automatic int exp_ack_cycle(input int h);
    return (h + 2 > MIN_CYCLES + 1) ? h + 2 : MIN_CYCLES + 1;
  endfunction

  // Runs one xbus access against a small controller model.
  //   done_wait : the number of strobe cycles with sdram_done=0 before it rises
  //   ready_lat : the cycles after the accepted read strobe until sdram_ready (-1 = never)
  //   hold_after: the cycles xbus_req stays high after the ack
  task automatic run_access(input string name, input logic wr, input logic [21:0] addr,
                            input logic [31:0] data, input int done_wait, input int ready_lat,
                            input logic [31:0] rdata, input int hold_after,
                            input int exp_ack, input logic exp_to, input int exp_strobes);
    int   c       = 0;
    int   acks    = 0;
    int   strobes = 0;
    int   ack_c   = -1;
    int   acc_c   = -1;
    bit   seen    = 0;
    exp_t e, got;
    e.data    = wr ? model_rd : (exp_to ? 32'hFFFF_FFFF : rdata);
    e.timeout = exp_to;
    model_rd  = e.data;

    @(negedge clk);
    xbus_req     = 1'b1;
    xbus_write   = wr;
    xbus_addr    = addr;
    xbus_data_in = data;
    sdram_done   = 1'b0;
    sdram_ready  = 1'b0;
    sb.push_back(e);

    while (c < 40 && !(seen && c >= ack_c + hold_after)) begin
      @(negedge clk);
      c++;
      if (sdram_req || sdram_write) begin
        strobes++;
        check({name, "_strobe_kind"}, {sdram_req, sdram_write}, wr ? 2'b01 : 2'b10);
        check({name, "_strobe_addr"}, sdram_addr, addr);
        if (wr) check({name, "_strobe_data"}, sdram_data_in, data);
      end
      if (xbus_timeout) check({name, "_timeout_with_ack"}, xbus_ack, 1);
      if (xbus_ack) begin
        acks++;
        if (!seen) begin
          seen  = 1;
          ack_c = c;
        end
        if (sb.size() == 0) check({name, "_ack_unexpected"}, 1, 0);
        else begin
          got = sb.pop_front();
          check({name, "_rdata"}, xbus_data_out, got.data);
          check({name, "_timeout"}, xbus_timeout, got.timeout);
        end
      end
      // Controller model for this cycle.
      sdram_ready    = 1'b0;
      sdram_data_out = 32'h0BAD_0BAD;
      sdram_done     = (c > done_wait);
      if (acc_c < 0 && (sdram_req || sdram_write) && sdram_done) acc_c = c;
      if (acc_c >= 0 && ready_lat >= 0 && c == acc_c + ready_lat) begin
        sdram_ready    = 1'b1;
        sdram_data_out = rdata;
      end
    end

    xbus_req    = 1'b0;
    sdram_ready = 1'b0;
    check({name, "_ack_count"}, acks, 1);
    check({name, "_ack_cycle"}, ack_c, exp_ack);
    check({name, "_strobe_cycles"}, strobes, exp_strobes);
    check({name, "_sb_empty"}, sb.size(), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    check({name, "_idle_busy"}, xbus_busy, 0);
    check({name, "_idle_ack"}, xbus_ack, 0);
    check({name, "_data_held"}, xbus_data_out, model_rd);
    sdram_done = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    xbus_addr      = '0;
    xbus_data_in   = '0;
    xbus_req       = 1'b0;
    xbus_write     = 1'b0;
    sdram_data_out = '0;
    sdram_done     = 1'b0;
    sdram_ready    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack", xbus_ack, 0);
    check("rst_timeout", xbus_timeout, 0);
    check("rst_busy", xbus_busy, 0);
    check("rst_strobes", {sdram_req, sdram_write}, 2'b00);
    check("rst_data_out", xbus_data_out, 32'h0);
    check("rst_sdram_addr", sdram_addr, 22'h0);
    check("rst_sdram_data", sdram_data_in, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Read with an idle controller: ready 2 cycles after the strobe, HOLD
    // left at cycle 4, ack at MIN_CYCLES+1.
    run_access("rd_idle", 1'b0, 22'h001234, 32'h0, 0, 2, 32'hDEAD_BEEF, 0,
               exp_ack_cycle(3), 1'b0, 1);
    // Write with 5 cycles of backpressure: strobe in cycles 1..6, HOLD at 7.
    run_access("wr_bp", 1'b1, 22'h00ABCD, 32'h0000_A5A5, 5, -1, 32'h0, 0,
               exp_ack_cycle(6), 1'b0, 6);
    // Read where the data never comes back: timeout and ack at cycle 16.
    run_access("rd_timeout", 1'b0, 22'h3FFFFF, 32'h0, 0, -1, 32'h0, 0,
               TIMEOUT_CYCLES, 1'b1, 1);
    // The request is held for 20 cycles after the ack and must not be serviced again.
    run_access("rd_held", 1'b0, 22'h000042, 32'h0, 0, 1, 32'h1234_5678, 20,
               exp_ack_cycle(2), 1'b0, 1);
    // Read with backpressure and slow data: accepted at 4, ready at 8.
    run_access("rd_slow", 1'b0, 22'h2AAAAA, 32'h0, 3, 4, 32'hC001_D00D, 0,
               exp_ack_cycle(8), 1'b0, 4);

    // Reset while in RD_WAIT.
    @(negedge clk);
    xbus_req = 1'b1; xbus_write = 1'b0; xbus_addr = 22'h005555;
    @(negedge clk);                       // cycle 1: RD_CMD
    check("rstmid_rd_strobe", sdram_req, 1);
    sdram_done = 1'b1;
    @(negedge clk);                       // cycle 2: RD_WAIT
    check("rstmid_in_wait", {xbus_busy, sdram_req}, 2'b10);
    sdram_done = 1'b0;
    reset      = 1'b1;
    @(negedge clk);                       // the reset edge has passed
    check("rstmid_outs", {xbus_ack, xbus_timeout, xbus_busy, sdram_req, sdram_write}, 5'b0);
    check("rstmid_data", xbus_data_out, 32'h0);
    check("rstmid_addr", sdram_addr, 22'h0);
    reset    = 1'b0;
    xbus_req = 1'b0;
    @(negedge clk);
    sdram_ready = 1'b1; sdram_data_out = 32'h7777_7777;
    @(negedge clk);
    sdram_ready = 1'b0;
    check("rstmid_late_ready_ack", xbus_ack, 0);
    check("rstmid_late_ready_data", xbus_data_out, 32'h0);
    check("rstmid_late_ready_busy", xbus_busy, 0);
    model_rd = 32'h0;

`ifdef XBUS_SDRAM_POSTED_WRITE_EN
    begin : posted
      int acks     = 0;
      int wr_last  = -1;
      int first_rd = -1;
      int rd_acc   = -1;
      int rd_ack   = -1;
      @(negedge clk);
      xbus_req = 1'b1; xbus_write = 1'b1; xbus_addr = 22'h000777; xbus_data_in = 32'h0000_CAFE;
      sdram_done = 1'b0;
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
        if (c == 1) check("pw_write_ack_c1", xbus_ack, 1);
        if (c == 5) check("pw_busy_draining", xbus_busy, 1);
        if (xbus_ack) acks++;
        if (xbus_ack && c > 1 && rd_ack < 0) begin
          rd_ack = c;
          check("pw_rd_data", xbus_data_out, 32'h5151_5151);
        end
        if (sdram_write) wr_last = c;
        if (sdram_req && first_rd < 0) first_rd = c;
        // CPU: drop the request after the write ack, then issue a read right away.
        if (c == 1) xbus_req = 1'b0;
        if (c == 2) begin
          xbus_req = 1'b1; xbus_write = 1'b0; xbus_addr = 22'h000888;
        end
        if (rd_ack >= 0) xbus_req = 1'b0;
        sdram_done     = (c > 8);
        sdram_ready    = 1'b0;
        sdram_data_out = 32'h0BAD_0BAD;
        if (rd_acc < 0 && sdram_req && sdram_done) rd_acc = c;
        if (rd_acc >= 0 && c == rd_acc + 2) begin
          sdram_ready = 1'b1; sdram_data_out = 32'h5151_5151;
        end
      end
      // The write drains at 9, the read is accepted in IDLE at 10 and
      // strobes at 11, ready comes at 13, and HOLD at 14 with the counter at 3.
      check("pw_write_last", wr_last, 9);
      check("pw_read_first", first_rd, 11);
      check("pw_read_ack", rd_ack, 15);
      check("pw_ack_total", acks, 2);
      check("pw_final_busy", xbus_busy, 0);
      sdram_done = 1'b0; sdram_ready = 1'b0;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Stops the run if the sequence stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got=stalled expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
